cam_capture_scaled: RTL and testbench

//  Captures OV7670-style 8-bit parallel pixel stream (2 bytes/pixel) into dual-port frame RAM as DW-bit RGB444.

---
 rtl/cam_capture_scaled_if.sv | 36 +++
 rtl/cam_capture_scaled.sv | 174 +++++++++++++++++
 tb/tb_cam_capture_scaled.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_capture_scaled_if.sv
`default_nettype none
// ============================================================================
//  cam_capture_scaled_if
//  Camera-pin / control / frame-buffer write bundle for cam_capture_scaled.
//  Revision: 1.0
// ============================================================================
interface cam_capture_scaled_if #(
    parameter int AW = 15,
    parameter int DW = 12
);
    logic          CAM_vsync;
    logic          CAM_href;
    logic [7:0]    CAM_px_data;
    logic          fmt_565;
    logic          continuous;
    logic          start;
    logic          DP_RAM_regW;
    logic [AW-1:0] DP_RAM_addr_in;
    logic [DW-1:0] DP_RAM_data_in;
    logic          busy;
    logic          frame_done;
    logic          ovf;

    // Camera pins and control side.
    modport master (
        output CAM_vsync, CAM_href, CAM_px_data, fmt_565, continuous, start,
        input  DP_RAM_regW, DP_RAM_addr_in, DP_RAM_data_in, busy, frame_done, ovf
    );

    // Capture block side.
    modport slave (
        input  CAM_vsync, CAM_href, CAM_px_data, fmt_565, continuous, start,
        output DP_RAM_regW, DP_RAM_addr_in, DP_RAM_data_in, busy, frame_done, ovf
    );
endinterface
`default_nettype wire

// File: rtl/cam_capture_scaled.sv
`default_nettype none
// ============================================================================
//  cam_capture_scaled
//  Two-byte-per-pixel camera capture with 2^SCALE decimation, bounds clipping
//  and RGB444/RGB565 to RGB444 conversion into a frame-buffer write port.
//  Revision: 1.0
// ============================================================================
module cam_capture_scaled #(
    parameter int AW    = 15,
    parameter int DW    = 12,
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int SCALE = 2
) (
    input  wire logic            CAM_pclk,
    input  wire logic            rst,
    cam_capture_scaled_if.slave  bus
);

    localparam int              CNT_W     = 16;
    localparam logic [CNT_W-1:0] KEEP_MASK = CNT_W'((1 << SCALE) - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYNC  = 3'd1,
        S_BYTE1 = 3'd2,
        S_BYTE2 = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t            state_q;
    logic              armed_q;
    logic              fmt565_q;
    logic [7:0]        byte1_q;
    logic [CNT_W-1:0]  raw_col_q;
    logic [CNT_W-1:0]  raw_line_q;
    logic [AW-1:0]     row_base_q;
    logic              regW_q;
    logic [AW-1:0]     addr_q;
    logic [DW-1:0]     data_q;
    logic              busy_q;
    logic              done_q;
    logic              ovf_q;

    logic [CNT_W-1:0]  kept_col_d;
    logic [CNT_W-1:0]  kept_line_d;
    logic [CNT_W-1:0]  line_inc_d;
    logic              keep_d;
    logic              in_bounds_d;
    logic              line_kept_d;
    logic [11:0]       pixel_d;
    logic [AW-1:0]     wr_addr_d;

    // Counters saturate so a runaway line or frame can never wrap back in bounds.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        kept_col_d  = raw_col_q >> SCALE;
        kept_line_d = raw_line_q >> SCALE;
        line_inc_d  = sat_inc(raw_line_q);
        keep_d      = ((raw_col_q & KEEP_MASK) == '0) && ((raw_line_q & KEEP_MASK) == '0);
        in_bounds_d = (kept_col_d < CNT_W'(IMG_W)) && (kept_line_d < CNT_W'(IMG_H));
        line_kept_d = ((line_inc_d & KEEP_MASK) == '0);
        wr_addr_d   = row_base_q + AW'(kept_col_d);
        if (fmt565_q)
            pixel_d = {byte1_q[7:4], byte1_q[2:0], bus.CAM_px_data[7], bus.CAM_px_data[4:1]};
        else
            pixel_d = {byte1_q[3:0], bus.CAM_px_data};
    end

    always_ff @(posedge CAM_pclk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            armed_q    <= 1'b0;
            fmt565_q   <= 1'b0;
            byte1_q    <= '0;
            raw_col_q  <= '0;
            raw_line_q <= '0;
            row_base_q <= '0;
            regW_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            regW_q <= 1'b0;
            done_q <= 1'b0;
            // A start pulse only counts while no frame is being captured.
            if (bus.start && !busy_q) begin
                armed_q <= 1'b1;
                ovf_q   <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if ((armed_q || bus.start || bus.continuous) && bus.CAM_vsync)
                        state_q <= S_SYNC;
                end

                S_SYNC: begin
                    if (!bus.CAM_vsync && bus.CAM_href) begin
                        fmt565_q   <= bus.fmt_565;
                        addr_q     <= '0;
                        raw_col_q  <= '0;
                        raw_line_q <= '0;
                        row_base_q <= '0;
                        busy_q     <= 1'b1;
                        armed_q    <= 1'b0;
                        byte1_q    <= bus.CAM_px_data;
                        state_q    <= S_BYTE2;
                    end
                end

                S_BYTE1: begin
                    if (bus.CAM_href) begin
                        byte1_q <= bus.CAM_px_data;
                        state_q <= S_BYTE2;
                    end else begin
                        state_q <= S_GAP;
                    end
                end

                S_BYTE2: begin
                    // href dropping here leaves a half pixel, which is dropped.
                    if (bus.CAM_href) begin
                        if (keep_d) begin
                            if (in_bounds_d) begin
                                regW_q <= 1'b1;
                                addr_q <= wr_addr_d;
                                data_q <= DW'(pixel_d);
                            end else begin
                                ovf_q <= 1'b1;
                            end
                        end
                        raw_col_q <= sat_inc(raw_col_q);
                        state_q   <= S_BYTE1;
                    end else begin
                        state_q <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (bus.CAM_vsync) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= bus.continuous ? S_SYNC : S_IDLE;
                    end else if (bus.CAM_href) begin
                        // Each kept line restarts at its own row base, so short lines leave holes.
                        raw_col_q  <= '0;
                        raw_line_q <= line_inc_d;
                        if (line_kept_d)
                            row_base_q <= row_base_q + AW'(IMG_W);
                        byte1_q    <= bus.CAM_px_data;
                        state_q    <= S_BYTE2;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.DP_RAM_regW    = regW_q;
    assign bus.DP_RAM_addr_in = addr_q;
    assign bus.DP_RAM_data_in = data_q;
    assign bus.busy           = busy_q;
    assign bus.frame_done     = done_q;
    assign bus.ovf            = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_capture_scaled.sv
`default_nettype none
// ============================================================================
//  tb_cam_capture_scaled
//  Directed bench: DUT A (SCALE=0, 4x2) and DUT B (SCALE=1, 4x2) share stimulus.
//  Revision: 1.0
// ============================================================================
module tb_cam_capture_scaled;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vsync = 1'b0, href = 1'b0, fmt = 1'b0, cont = 1'b0, start = 1'b0;
    logic [7:0] pxd = 8'h00;

    always #5 clk = ~clk;

    cam_capture_scaled_if #(.AW(15), .DW(12)) ifa ();
    cam_capture_scaled_if #(.AW(15), .DW(12)) ifb ();

    assign ifa.CAM_vsync = vsync;  assign ifb.CAM_vsync = vsync;
    assign ifa.CAM_href  = href;   assign ifb.CAM_href  = href;
    assign ifa.CAM_px_data = pxd;  assign ifb.CAM_px_data = pxd;
    assign ifa.fmt_565   = fmt;    assign ifb.fmt_565   = fmt;
    assign ifa.continuous = cont;  assign ifb.continuous = cont;
    assign ifa.start     = start;  assign ifb.start     = start;

    cam_capture_scaled #(.AW(15), .DW(12), .IMG_W(4), .IMG_H(2), .SCALE(0)) u_dut_a (
        .CAM_pclk (clk),
        .rst      (rst),
        .bus      (ifa.slave)
    );

    cam_capture_scaled #(.AW(15), .DW(12), .IMG_W(4), .IMG_H(2), .SCALE(1)) u_dut_b (
        .CAM_pclk (clk),
        .rst      (rst),
        .bus      (ifb.slave)
    );

    logic [31:0] a_addr[$], a_data[$], b_addr[$], b_data[$];
    int          a_done = 0, b_done = 0;

    always @(negedge clk) begin
        if (ifa.DP_RAM_regW === 1'b1) begin
            a_addr.push_back(32'(ifa.DP_RAM_addr_in));
            a_data.push_back(32'(ifa.DP_RAM_data_in));
        end
        if (ifb.DP_RAM_regW === 1'b1) begin
            b_addr.push_back(32'(ifb.DP_RAM_addr_in));
            b_data.push_back(32'(ifb.DP_RAM_data_in));
        end
        if (ifa.frame_done === 1'b1) a_done++;
        if (ifb.frame_done === 1'b1) b_done++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    // Pixel byte source: either a 4-entry table by column, or line/column encoded.
    logic [7:0] pb1[4], pb2[4];
    bit         pat_lc = 1'b0;

    function automatic logic [7:0] byte_a(input int l, input int p);
        logic [3:0] ln = 4'(l);
        return pat_lc ? {4'h0, ln} : pb1[p % 4];
    endfunction

    function automatic logic [7:0] byte_b(input int l, input int p);
        logic [3:0] cn = 4'(p);
        return pat_lc ? {cn, 4'h5} : pb2[p % 4];
    endfunction

    task automatic send_frame(input int lines, input int pix, input int pix_first,
                              input bit half, input bit flip_fmt);
        vsync = 1'b1; repeat (4) tick();
        vsync = 1'b0; repeat (3) tick();
        for (int l = 0; l < lines; l++) begin
            int np;
            np = (l == 0) ? pix_first : pix;
            for (int p = 0; p < np; p++) begin
                href = 1'b1; pxd = byte_a(l, p); tick();
                pxd = byte_b(l, p); tick();
            end
            if (l == 0 && half) begin
                href = 1'b1; pxd = byte_a(l, np); tick();
            end
            href = 1'b0; pxd = 8'h00; repeat (3) tick();
            if (l == 0 && flip_fmt) fmt = ~fmt;
        end
        vsync = 1'b1; repeat (4) tick();
        vsync = 1'b0; repeat (2) tick();
    endtask

    logic [31:0] exp_addr[$], exp_data[$];

    task automatic compare_writes(input string tag, input bit dut_b, input int base);
        int n;
        n = (dut_b ? b_addr.size() : a_addr.size()) - base;
        check_eq({tag, "_count"}, 32'(n), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < n; i++) begin
            check_eq($sformatf("%s_addr%0d", tag, i),
                     dut_b ? b_addr[base + i] : a_addr[base + i], exp_addr[i]);
            check_eq($sformatf("%s_data%0d", tag, i),
                     dut_b ? b_data[base + i] : a_data[base + i], exp_data[i]);
        end
    endtask

    task automatic set_const(input logic [7:0] x1, input logic [7:0] x2,
                             input logic [7:0] y1, input logic [7:0] y2);
        pat_lc = 1'b0;
        pb1[0] = x1; pb2[0] = x2; pb1[1] = y1; pb2[1] = y2;
        pb1[2] = x1; pb2[2] = x2; pb1[3] = y1; pb2[3] = y2;
    endtask

    initial begin
        int base_a, base_b, done_a;

        repeat (3) tick();
        check_eq("rst_regW",  32'(ifa.DP_RAM_regW),    32'h0);
        check_eq("rst_addr",  32'(ifa.DP_RAM_addr_in), 32'h0);
        check_eq("rst_data",  32'(ifa.DP_RAM_data_in), 32'h0);
        check_eq("rst_busy",  32'(ifa.busy),           32'h0);
        check_eq("rst_done",  32'(ifa.frame_done),     32'h0);
        check_eq("rst_ovf",   32'(ifa.ovf),            32'h0);
        rst = 1'b0;
        tick();

        // 1: RGB444 constant pixels, full 4x2 frame.
        set_const(8'h0A, 8'hBC, 8'h0A, 8'hBC);
        base_a = a_addr.size(); done_a = a_done;
        pulse_start();
        send_frame(2, 4, 4, 1'b0, 1'b0);
        exp_addr.delete(); exp_data.delete();
        for (int i = 0; i < 8; i++) begin
            exp_addr.push_back(32'(i)); exp_data.push_back(32'hABC);
        end
        compare_writes("t1", 1'b0, base_a);
        check_eq("t1_done", 32'(a_done - done_a), 32'd1);
        check_eq("t1_ovf",  32'(ifa.ovf),  32'h0);
        check_eq("t1_busy", 32'(ifa.busy), 32'h0);

        // 2: RGB565, fmt changed after line 0 must not affect this frame.
        set_const(8'hF8, 8'h1F, 8'h07, 8'hE0);
        fmt = 1'b1;
        base_a = a_addr.size();
        pulse_start();
        send_frame(2, 4, 4, 1'b0, 1'b1);
        fmt = 1'b0;
        exp_addr.delete(); exp_data.delete();
        for (int i = 0; i < 8; i++) begin
            exp_addr.push_back(32'(i));
            exp_data.push_back((i % 2 == 0) ? 32'hF0F : 32'h0F0);
        end
        compare_writes("t2", 1'b0, base_a);

        // 3: SCALE=1 on an 8x4 raw frame, line/column encoded pixels.
        pat_lc = 1'b1;
        base_b = b_addr.size();
        pulse_start();
        send_frame(4, 8, 8, 1'b0, 1'b0);
        exp_addr.delete(); exp_data.delete();
        for (int i = 0; i < 8; i++) begin
            exp_addr.push_back(32'(i));
            exp_data.push_back({20'h0, 4'(2 * (i / 4)), 4'(2 * (i % 4)), 4'h5});
        end
        compare_writes("t3", 1'b1, base_b);
        check_eq("t3_ovf", 32'(ifb.ovf), 32'h0);

        // 4: 6-pixel raw lines into IMG_W=4.
        base_a = a_addr.size();
        pulse_start();
        check_eq("t4_ovf_cleared", 32'(ifa.ovf), 32'h0);
        send_frame(2, 6, 6, 1'b0, 1'b0);
        exp_addr.delete(); exp_data.delete();
        for (int i = 0; i < 8; i++) begin
            exp_addr.push_back(32'(i));
            exp_data.push_back({20'h0, 4'(i / 4), 4'(i % 4), 4'h5});
        end
        compare_writes("t4", 1'b0, base_a);
        check_eq("t4_ovf", 32'(ifa.ovf), 32'h1);

        // 4b: short first line ending in a half pixel; line 1 starts at row base 4.
        base_a = a_addr.size();
        pulse_start();
        send_frame(2, 4, 2, 1'b1, 1'b0);
        exp_addr.delete(); exp_data.delete();
        exp_addr.push_back(32'd0); exp_data.push_back(32'h005);
        exp_addr.push_back(32'd1); exp_data.push_back(32'h015);
        for (int i = 0; i < 4; i++) begin
            exp_addr.push_back(32'(4 + i));
            exp_data.push_back({20'h0, 4'h1, 4'(i), 4'h5});
        end
        compare_writes("t4b", 1'b0, base_a);
        check_eq("t4b_ovf", 32'(ifa.ovf), 32'h0);

        // 5: single-shot, no start: nothing captured; then one start -> one frame.
        set_const(8'h0A, 8'hBC, 8'h0A, 8'hBC);
        base_a = a_addr.size(); base_b = b_addr.size(); done_a = a_done;
        send_frame(2, 4, 4, 1'b0, 1'b0);
        send_frame(2, 4, 4, 1'b0, 1'b0);
        check_eq("t5_idle_writes_a", 32'(a_addr.size() - base_a), 32'd0);
        check_eq("t5_idle_writes_b", 32'(b_addr.size() - base_b), 32'd0);
        check_eq("t5_idle_done", 32'(a_done - done_a), 32'd0);
        base_a = a_addr.size(); done_a = a_done;
        pulse_start();
        send_frame(2, 4, 4, 1'b0, 1'b0);
        send_frame(2, 4, 4, 1'b0, 1'b0);
        check_eq("t5_shot_writes", 32'(a_addr.size() - base_a), 32'd8);
        check_eq("t5_shot_done", 32'(a_done - done_a), 32'd1);

        // 6: reset in the cycle carrying byte 2 of the third pixel.
        done_a = a_done;
        pulse_start();
        vsync = 1'b1; repeat (4) tick();
        vsync = 1'b0; repeat (3) tick();
        for (int p = 0; p < 2; p++) begin
            href = 1'b1; pxd = 8'h0A; tick();
            pxd = 8'hBC; tick();
        end
        check_eq("t6_busy_mid", 32'(ifa.busy), 32'h1);
        pxd = 8'h0A; tick();
        pxd = 8'hBC; rst = 1'b1; tick();
        check_eq("t6_rst_regW", 32'(ifa.DP_RAM_regW),    32'h0);
        check_eq("t6_rst_busy", 32'(ifa.busy),           32'h0);
        check_eq("t6_rst_addr", 32'(ifa.DP_RAM_addr_in), 32'h0);
        rst = 1'b0; href = 1'b0; pxd = 8'h00;
        repeat (3) tick();
        vsync = 1'b1; repeat (4) tick();
        vsync = 1'b0; repeat (2) tick();
        check_eq("t6_no_done", 32'(a_done - done_a), 32'd0);
        base_a = a_addr.size();
        pulse_start();
        send_frame(2, 4, 4, 1'b0, 1'b0);
        exp_addr.delete(); exp_data.delete();
        for (int i = 0; i < 8; i++) begin
            exp_addr.push_back(32'(i)); exp_data.push_back(32'hABC);
        end
        compare_writes("t6", 1'b0, base_a);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
